// File: rtl/serial_subtractor_ctrl_pkg.sv
// rtl/serial_subtractor_ctrl_pkg.sv - shared state type and default width for serial arithmetic controllers
package serial_subtractor_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// rtl/serial_subtractor_ctrl_if.sv - operand/result handshake bundle for the serial subtractor
interface serial_subtractor_ctrl_if
   import serial_subtractor_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf, busy
   );

endinterface

// File: rtl/serial_subtractor_ctrl_full_subtractor.sv
// rtl/serial_subtractor_ctrl_full_subtractor.sv - single-bit full subtractor cell, d = x - y - bi
module serial_subtractor_ctrl_full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial subtraction sequencer, one shared cell, LSB first
module serial_subtractor_ctrl
   import serial_subtractor_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   serial_subtractor_ctrl_if.slave bus
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             cell_d, cell_bo;

   serial_subtractor_ctrl_full_subtractor u_cell (
      .x  (sa_q[0]),
      .y  (sb_q[0]),
      .bi (br_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sa_d    = bus.a;
               sb_d    = bus.b;
               br_d    = bus.bin;
               cnt_d   = '0;
               a_msb_d = bus.a[WIDTH-1];
               b_msb_d = bus.b[WIDTH-1];
               state_d = RUN;
            end
         end
         RUN: begin
            // Result bits enter from the top so bit 0 lands at diff_q[0] after WIDTH shifts.
            sa_d   = sa_q >> 1;
            sb_d   = sb_q >> 1;
            diff_d = {cell_d, diff_q[WIDTH-1:1]};
            br_d   = cell_bo;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q == RUN) || (state_q == DONE);
   assign bus.diff      = diff_q;
   assign bus.bout      = br_q;
   assign bus.ovf       = (a_msb_q != b_msb_q) && (diff_q[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - scoreboard bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=2
module tb_serial_subtractor_ctrl;

   typedef struct packed {
      logic [31:0] d;
      logic        bo;
      logic        ov;
   } res_t;

   logic clk = 1'b0;
   logic rst8_n;
   logic rst2_n;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   bp2_en = 1'b0;
   res_t q8[$];
   res_t q2[$];

   always #5 clk = ~clk;

   serial_subtractor_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_ctrl_if #(.WIDTH(2)) bus2 ();

   serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));
   serial_subtractor_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Independent reference: modular difference, unsigned borrow, signed range check.
   function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv, input logic bi);
      res_t   r;
      longint m, half, ua, ub, full, sa, sb, sr;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(av) & m;
      ub   = longint'(bv) & m;
      full = ua - ub - longint'(bi);
      r.d  = 32'(full & m);
      r.bo = (full < 0);
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      sr   = sa - sb - longint'(bi);
      r.ov = (sr < -half) || (sr >= half);
      return r;
   endfunction

   task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic bi, input res_t e);
      int n = 0;
      bus8.in_valid = 1'b1;
      bus8.a = av;
      bus8.b = bv;
      bus8.bin = bi;
      @(negedge clk);
      while (!bus8.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus8.in_ready) chk("send8_timeout", 32'd0, 32'd1);
      else q8.push_back(e);
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
   endtask

   task automatic send2(input logic [1:0] av, input logic [1:0] bv, input logic bi);
      int n = 0;
      bus2.in_valid = 1'b1;
      bus2.a = av;
      bus2.b = bv;
      bus2.bin = bi;
      @(negedge clk);
      while (!bus2.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus2.in_ready) chk("send2_timeout", 32'd0, 32'd1);
      else q2.push_back(model(2, {30'd0, av}, {30'd0, bv}, bi));
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0;
   endtask

   task automatic wait_result8(output int lat);
      lat = 0;
      while (!bus8.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus8.out_valid) chk("wait8_timeout", 32'd0, 32'd1);
   endtask

   always @(negedge clk) begin
      res_t e;
      if (rst8_n && bus8.out_valid && bus8.out_ready) begin
         if (q8.size() == 0) chk("sb8_unexpected", 32'd1, 32'd0);
         else begin
            e = q8.pop_front();
            chk("diff8", {24'd0, bus8.diff}, e.d);
            chk("bout8", {31'd0, bus8.bout}, {31'd0, e.bo});
            chk("ovf8", {31'd0, bus8.ovf}, {31'd0, e.ov});
         end
      end
   end

   logic [1:0] h2_d;
   logic       h2_bo, h2_ov;
   bit         h2_valid = 1'b0;

   always @(negedge clk) begin
      res_t e;
      if (h2_valid && bus2.out_valid) begin
         chk("hold2_diff", {30'd0, bus2.diff}, {30'd0, h2_d});
         chk("hold2_bout", {31'd0, bus2.bout}, {31'd0, h2_bo});
         chk("hold2_ovf", {31'd0, bus2.ovf}, {31'd0, h2_ov});
      end
      h2_valid = rst2_n && bus2.out_valid && !bus2.out_ready;
      h2_d  = bus2.diff;
      h2_bo = bus2.bout;
      h2_ov = bus2.ovf;
      if (rst2_n && bus2.out_valid && bus2.out_ready) begin
         if (q2.size() == 0) chk("sb2_unexpected", 32'd1, 32'd0);
         else begin
            e = q2.pop_front();
            chk("diff2", {30'd0, bus2.diff}, e.d);
            chk("bout2", {31'd0, bus2.bout}, {31'd0, e.bo});
            chk("ovf2", {31'd0, bus2.ovf}, {31'd0, e.ov});
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (bp2_en) bus2.out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      int          lat;
      int          n;
      logic [7:0]  ra, rb;
      logic [1:0]  sa2, sb2;
      logic        rbi;
      logic [9:0]  held;

      rst8_n = 1'b0;
      rst2_n = 1'b0;
      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0; bus8.out_ready = 1'b1;
      bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.bin = 1'b0; bus2.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus8.busy}, 32'd0);
      chk("rst_diff", {24'd0, bus8.diff}, 32'd0);
      chk("rst_bout", {31'd0, bus8.bout}, 32'd0);
      chk("rst_ovf", {31'd0, bus8.ovf}, 32'd0);
      rst8_n = 1'b1;
      rst2_n = 1'b1;
      @(posedge clk);
      #1;

      send8(8'h35, 8'h12, 1'b0, '{32'h23, 1'b0, 1'b0});
      chk("run_busy", {31'd0, bus8.busy}, 32'd1);
      chk("run_in_ready", {31'd0, bus8.in_ready}, 32'd0);
      wait_result8(lat);
      chk("latency", 32'(lat), 32'd8);
      @(posedge clk);
      #1;
      chk("ready_after_hs", {31'd0, bus8.in_ready}, 32'd1);
      chk("valid_after_hs", {31'd0, bus8.out_valid}, 32'd0);

      send8(8'h00, 8'h01, 1'b0, '{32'hFF, 1'b1, 1'b0});
      send8(8'h10, 8'h10, 1'b1, '{32'hFF, 1'b1, 1'b0});
      send8(8'h80, 8'h01, 1'b0, '{32'h7F, 1'b0, 1'b1});
      wait_result8(lat);
      @(posedge clk);
      #1;

      bus8.out_ready = 1'b0;
      send8(8'h7F, 8'hFF, 1'b0, '{32'h80, 1'b1, 1'b1});
      wait_result8(lat);
      held = {bus8.diff, bus8.bout, bus8.ovf};
      bus8.in_valid = 1'b1;
      bus8.a = 8'h44;
      bus8.b = 8'h22;
      bus8.bin = 1'b1;
      q8.push_back('{32'h21, 1'b0, 1'b0});
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_hold", {22'd0, bus8.diff, bus8.bout, bus8.ovf}, {22'd0, held});
         chk("bp_in_ready", {31'd0, bus8.in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, bus8.out_valid}, 32'd1);
      end
      bus8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_ready", {31'd0, bus8.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("bp_accept_busy", {31'd0, bus8.busy}, 32'd1);
      chk("bp_accept_ready", {31'd0, bus8.in_ready}, 32'd0);
      bus8.in_valid = 1'b0;
      wait_result8(lat);
      chk("bp_latency", 32'(lat), 32'd8);
      @(posedge clk);
      #1;

      send8(8'h55, 8'h0F, 1'b0, '{32'h46, 1'b0, 1'b0});
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_busy", {31'd0, bus8.busy}, 32'd1);
      rst8_n = 1'b0;
      #1;
      q8.delete();
      chk("abort_out_valid", {31'd0, bus8.out_valid}, 32'd0);
      chk("abort_busy", {31'd0, bus8.busy}, 32'd0);
      chk("abort_in_ready", {31'd0, bus8.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst8_n = 1'b1;
      @(posedge clk);
      #1;
      send8(8'h0A, 8'h03, 1'b0, '{32'h07, 1'b0, 1'b0});
      wait_result8(lat);
      @(posedge clk);
      #1;

      for (int i = 0; i < 25; i++) begin
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rbi = 1'($urandom_range(0, 1));
         send8(ra, rb, rbi, model(8, {24'd0, ra}, {24'd0, rb}, rbi));
      end

      bp2_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         sa2 = 2'($urandom_range(0, 3));
         sb2 = 2'($urandom_range(0, 3));
         rbi = 1'($urandom_range(0, 1));
         send2(sa2, sb2, rbi);
      end

      n = 0;
      while ((q8.size() != 0 || q2.size() != 0) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain8", 32'(q8.size()), 32'd0);
      chk("drain2", 32'(q2.size()), 32'd0);
      bp2_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
